led_blink_monitor: RTL and testbench

- Checker stage that sits directly downstream of the PLL-driven LED blinker; consumes its four LED lines in the same clock domain.
- Per channel, measures the clock-cycle interval between consecutive LED toggles and checks it against an expected half-period window.
- Flags out-of-window intervals and stalled channels with sticky bits.
- Exposes the last measured interval of one selected channel for board debug and bench checking.

---
 rtl/led_blink_monitor.sv | 134 +++++++++++++
 tb/tb_led_blink_monitor.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_monitor.sv
// led_blink_monitor
//
// Watches the four LED lines of the PLL-driven blinker and measures, per
// channel, the number of clock cycles between consecutive toggles. Each
// measured interval is compared against the window
// [EXP_PERIOD-TOL, EXP_PERIOD+TOL]. Out-of-window intervals and channels that
// stop toggling raise sticky status bits. One channel's last interval is
// exposed on Period for board debug.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Rst_n    in   synchronous active-low reset
//   LED      in   [3:0] LED lines, synchronous to Clk
//   Clr      in   synchronous clear of all status and measurement state
//   Sel      in   [1:0] channel select for the Period readout
//   Period   out  [PW-1:0] last measured interval of channel Sel (registered)
//   Valid    out  [3:0] channel has measured at least one full interval
//   Err      out  [3:0] sticky: a measured interval fell outside the window
//   Stall    out  [3:0] sticky: no toggle within EXP_PERIOD+TOL cycles
//   Err_any  out  OR of Err and Stall, registered
//
// Per-channel FSM:
//   state   | meaning
//   IDLE    | no edge seen since reset/clear; waiting to arm
//   MEASURE | armed on a previous edge; counting cycles to the next edge
//
// EXP_PERIOD-TOL must be at least 1.

module led_blink_monitor #(
  parameter int PW         = 26,
  parameter int EXP_PERIOD = 25_000_000,
  parameter int TOL        = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [3:0]    LED,
  input  logic          Clr,
  input  logic [1:0]    Sel,
  output logic [PW-1:0] Period,
  output logic [3:0]    Valid,
  output logic [3:0]    Err,
  output logic [3:0]    Stall,
  output logic          Err_any
);

  localparam logic [PW-1:0] WIN_LO   = PW'(EXP_PERIOD - TOL);
  localparam logic [PW-1:0] WIN_HI   = PW'(EXP_PERIOD + TOL);
  // First count value past the window: the channel has gone silent.
  localparam logic [PW-1:0] STALL_AT = PW'(EXP_PERIOD + TOL + 1);
  localparam logic [PW-1:0] CNT_MAX  = {PW{1'b1}};
  localparam logic [PW-1:0] ONE      = PW'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t        state   [4];
  logic [PW-1:0] cnt     [4];
  logic [PW-1:0] per     [4];
  logic [PW-1:0] cnt_inc [4];
  logic [3:0]    out_win;
  logic [3:0]    LED_q;
  logic [3:0]    e;

  // A toggle is seen in the first cycle the new level appears on LED.
  assign e = LED ^ LED_q;

  // cnt+1 with saturation; this is both the next count and the interval
  // length if an edge arrives in this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_inc[i] = (cnt[i] == CNT_MAX) ? CNT_MAX : cnt[i] + ONE;
      out_win[i] = (cnt_inc[i] < WIN_LO) || (cnt_inc[i] > WIN_HI);
    end
  end

  always_ff @(posedge Clk) begin
    // LED_q follows LED even through reset and clear, so a line that is
    // already high when reset releases does not look like an edge.
    LED_q <= LED;

    if (!Rst_n || Clr) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        per[i]   <= '0;
      end
      Valid   <= '0;
      Err     <= '0;
      Stall   <= '0;
      Period  <= '0;
      Err_any <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (state[i])
          IDLE: begin
            // The partial interval before the first edge is not measured.
            if (e[i]) begin
              state[i] <= MEASURE;
              cnt[i]   <= '0;
            end
          end
          MEASURE: begin
            if (e[i]) begin
              per[i]   <= cnt_inc[i];
              cnt[i]   <= '0;
              Valid[i] <= 1'b1;
              if (out_win[i]) begin
                Err[i] <= 1'b1;
              end
            end else begin
              cnt[i] <= cnt_inc[i];
              // Fires once per silent stretch; the channel keeps measuring
              // so a late edge still records the (over-range) interval.
              if (cnt_inc[i] == STALL_AT) begin
                Stall[i] <= 1'b1;
              end
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end

      Period  <= per[Sel];
      // Built from the registered status bits, so it trails them by a cycle.
      Err_any <= |(Err | Stall);
    end
  end

endmodule

// File: tb/tb_led_blink_monitor.sv
module tb_led_blink_monitor;

  localparam int PW         = 26;
  localparam int EXP_PERIOD = 25;
  localparam int TOL        = 1;

  logic          Clk;
  logic          Rst_n;
  logic [3:0]    LED;
  logic          Clr;
  logic [1:0]    Sel;
  logic [PW-1:0] Period;
  logic [3:0]    Valid;
  logic [3:0]    Err;
  logic [3:0]    Stall;
  logic          Err_any;

  led_blink_monitor #(
    .PW(PW),
    .EXP_PERIOD(EXP_PERIOD),
    .TOL(TOL)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .LED(LED),
    .Clr(Clr),
    .Sel(Sel),
    .Period(Period),
    .Valid(Valid),
    .Err(Err),
    .Stall(Stall),
    .Err_any(Err_any)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel arm flag, last edge cycle, expected
  // intervals (scoreboard), expected Valid and Err.
  bit         armed     [4];
  int         last_edge [4];
  int         exp_q     [4][$];
  logic [3:0] exp_valid;
  logic [3:0] exp_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      armed[i] = 1'b0;
      last_edge[i] = 0;
      exp_q[i].delete();
    end
    exp_valid = '0;
    exp_err   = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Toggle the masked lines so the edge is sampled at posedge cyc+1.
  task automatic drive_edges(input logic [3:0] mask);
    int t;
    int iv;
    t = cyc + 1;
    LED = LED ^ mask;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        if (armed[i]) begin
          iv = t - last_edge[i];
          exp_q[i].push_back(iv);
          exp_valid[i] = 1'b1;
          if (iv < EXP_PERIOD - TOL || iv > EXP_PERIOD + TOL) exp_err[i] = 1'b1;
        end
        armed[i] = 1'b1;
        last_edge[i] = t;
      end
    end
  endtask

  // Place an edge so it is sampled at posedge number 'target'; returns
  // sampling just after that edge.
  task automatic edge_at(input logic [3:0] mask, input int target);
    while (cyc < target - 1) tick();
    n_checks++;
    if (cyc != target - 1) begin
      n_fail++;
      $display("FAIL schedule: cycle %0d, wanted to drive before %0d", cyc, target);
    end
    drive_edges(mask);
    tick();
  endtask

  task automatic pop_exp(input int ch, output int v);
    if (exp_q[ch].size() == 0) v = -1;
    else v = exp_q[ch].pop_front();
  endtask

  task automatic do_clear();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Clr   = 1'b0;
    LED   = 4'b0000;
    Sel   = 2'd0;
    repeat (3) tick();
    model_reset();
    n_checks++; if (Period !== '0)     begin n_fail++; $display("FAIL reset_period: got %0d want 0", Period); end
    n_checks++; if (Valid !== 4'b0)    begin n_fail++; $display("FAIL reset_valid: got %b want 0000", Valid); end
    n_checks++; if (Err !== 4'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0000", Err); end
    n_checks++; if (Stall !== 4'b0)    begin n_fail++; $display("FAIL reset_stall: got %b want 0000", Stall); end
    n_checks++; if (Err_any !== 1'b0)  begin n_fail++; $display("FAIL reset_err_any: got %b want 0", Err_any); end
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_channel();
    int t0;
    int v;
    do_clear();
    Sel = 2'd0;
    t0 = cyc + 2;
    edge_at(4'b0001, t0);
    n_checks++; if (Valid !== exp_valid) begin n_fail++; $display("FAIL single_valid_arm: got %b want %b", Valid, exp_valid); end
    for (int k = 1; k <= 3; k++) begin
      edge_at(4'b0001, t0 + 25 * k);
      n_checks++; if (Valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b want 0001", Valid); end
      tick();
      pop_exp(0, v);
      n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL single_period: got %0d want %0d", Period, v); end
    end
    n_checks++; if (Err !== 4'b0)     begin n_fail++; $display("FAIL single_err: got %b want 0000", Err); end
    n_checks++; if (Stall !== 4'b0)   begin n_fail++; $display("FAIL single_stall: got %b want 0000", Stall); end
    n_checks++; if (Err_any !== 1'b0) begin n_fail++; $display("FAIL single_err_any: got %b want 0", Err_any); end
  endtask

  task automatic test_err_window();
    int t;
    int v;
    do_clear();
    Sel = 2'd1;
    t = cyc + 2;
    edge_at(4'b0010, t);
    edge_at(4'b0010, t + 25);
    n_checks++; if (Err !== exp_err) begin n_fail++; $display("FAIL win_err_good: got %b want %b", Err, exp_err); end
    tick();
    pop_exp(1, v);
    n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL win_period_25a: got %0d want %0d", Period, v); end
    edge_at(4'b0010, t + 52);
    n_checks++; if (Err !== 4'b0010)  begin n_fail++; $display("FAIL win_err_set: got %b want 0010", Err); end
    n_checks++; if (Err_any !== 1'b0) begin n_fail++; $display("FAIL win_err_any_lag: got %b want 0", Err_any); end
    tick();
    n_checks++; if (Err_any !== 1'b1) begin n_fail++; $display("FAIL win_err_any: got %b want 1", Err_any); end
    pop_exp(1, v);
    n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL win_period_27: got %0d want %0d", Period, v); end
    edge_at(4'b0010, t + 77);
    n_checks++; if (Err !== exp_err) begin n_fail++; $display("FAIL win_err_sticky: got %b want %b", Err, exp_err); end
    tick();
    pop_exp(1, v);
    n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL win_period_25b: got %0d want %0d", Period, v); end
  endtask

  task automatic test_stall();
    int t0;
    int v;
    do_clear();
    Sel = 2'd2;
    t0 = cyc + 27;
    edge_at(4'b0100, t0 - 25);
    edge_at(4'b0100, t0);
    while (cyc < t0 + 26) tick();
    n_checks++; if (Stall !== 4'b0)    begin n_fail++; $display("FAIL stall_early: got %b want 0000", Stall); end
    tick();
    n_checks++; if (Stall !== 4'b0100) begin n_fail++; $display("FAIL stall_set: got %b want 0100", Stall); end
    n_checks++; if (Err_any !== 1'b0)  begin n_fail++; $display("FAIL stall_err_any_lag: got %b want 0", Err_any); end
    tick();
    n_checks++; if (Err_any !== 1'b1)  begin n_fail++; $display("FAIL stall_err_any: got %b want 1", Err_any); end
    pop_exp(2, v);
    edge_at(4'b0100, t0 + 40);
    n_checks++; if (Err !== exp_err)   begin n_fail++; $display("FAIL stall_late_err: got %b want %b", Err, exp_err); end
    tick();
    pop_exp(2, v);
    n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL stall_late_period: got %0d want %0d", Period, v); end
  endtask

  task automatic test_back_to_back();
    int t;
    int v;
    do_clear();
    t = cyc + 2;
    edge_at(4'b1111, t);
    edge_at(4'b1000, t + 23);
    edge_at(4'b0001, t + 24);
    edge_at(4'b0010, t + 25);
    edge_at(4'b0100, t + 26);
    n_checks++; if (Err !== 4'b1000)   begin n_fail++; $display("FAIL b2b_err: got %b want 1000", Err); end
    n_checks++; if (Valid !== 4'b1111) begin n_fail++; $display("FAIL b2b_valid: got %b want 1111", Valid); end
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      tick();
      pop_exp(s, v);
      n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL b2b_period_sel%0d: got %0d want %0d", s, Period, v); end
    end
  endtask

  task automatic test_clear();
    int a;
    int v;
    do_clear();
    Sel = 2'd0;
    a = cyc + 2;
    edge_at(4'b1100, a);
    edge_at(4'b0100, a + 10);
    while (cyc < a + 28) tick();
    n_checks++; if (Err !== exp_err)   begin n_fail++; $display("FAIL clr_pre_err: got %b want %b", Err, exp_err); end
    n_checks++; if (Stall !== 4'b1000) begin n_fail++; $display("FAIL clr_pre_stall: got %b want 1000", Stall); end
    // Clear coincides with an LED0 edge; that edge must be ignored.
    LED = LED ^ 4'b0001;
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    model_reset();
    n_checks++; if (Period !== '0)    begin n_fail++; $display("FAIL clr_period: got %0d want 0", Period); end
    n_checks++; if (Valid !== 4'b0)   begin n_fail++; $display("FAIL clr_valid: got %b want 0000", Valid); end
    n_checks++; if (Err !== 4'b0)     begin n_fail++; $display("FAIL clr_err: got %b want 0000", Err); end
    n_checks++; if (Stall !== 4'b0)   begin n_fail++; $display("FAIL clr_stall: got %b want 0000", Stall); end
    n_checks++; if (Err_any !== 1'b0) begin n_fail++; $display("FAIL clr_err_any: got %b want 0", Err_any); end
    a = cyc + 5;
    edge_at(4'b0001, a);
    n_checks++; if (Valid !== exp_valid) begin n_fail++; $display("FAIL clr_arm_valid: got %b want %b", Valid, exp_valid); end
    edge_at(4'b0001, a + 25);
    n_checks++; if (Err !== 4'b0)     begin n_fail++; $display("FAIL clr_post_err: got %b want 0000", Err); end
    n_checks++; if (Valid !== 4'b0001) begin n_fail++; $display("FAIL clr_post_valid: got %b want 0001", Valid); end
    tick();
    pop_exp(0, v);
    n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL clr_post_period: got %0d want %0d", Period, v); end
  endtask

  task automatic test_reset_mid();
    int r;
    int v;
    do_clear();
    Sel = 2'd0;
    if (LED != 4'b0000) edge_at(LED, cyc + 2);
    edge_at(4'b1111, cyc + 3);
    repeat (10) tick();
    Rst_n = 1'b0;
    repeat (3) tick();
    model_reset();
    n_checks++; if (Period !== '0)    begin n_fail++; $display("FAIL rst_period: got %0d want 0", Period); end
    n_checks++; if (Valid !== 4'b0)   begin n_fail++; $display("FAIL rst_valid: got %b want 0000", Valid); end
    n_checks++; if (Err !== 4'b0)     begin n_fail++; $display("FAIL rst_err: got %b want 0000", Err); end
    n_checks++; if (Stall !== 4'b0)   begin n_fail++; $display("FAIL rst_stall: got %b want 0000", Stall); end
    n_checks++; if (Err_any !== 1'b0) begin n_fail++; $display("FAIL rst_err_any: got %b want 0", Err_any); end
    Rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (Valid !== 4'b0)   begin n_fail++; $display("FAIL rst_spurious_valid: got %b want 0000", Valid); end
    r = cyc + 2;
    edge_at(4'b0001, r);
    n_checks++; if (Valid !== exp_valid) begin n_fail++; $display("FAIL rst_arm_valid: got %b want %b", Valid, exp_valid); end
    edge_at(4'b0001, r + 25);
    n_checks++; if (Valid !== 4'b0001) begin n_fail++; $display("FAIL rst_meas_valid: got %b want 0001", Valid); end
    tick();
    pop_exp(0, v);
    n_checks++; if (Period !== PW'(v)) begin n_fail++; $display("FAIL rst_meas_period: got %0d want %0d", Period, v); end
    // Several cycles into channel 0's next interval, all other channels idle.
    n_checks++; if (Stall !== 4'b0)   begin n_fail++; $display("FAIL rst_final_stall: got %b want 0000", Stall); end
  endtask

  initial begin
    Rst_n = 1'b0;
    Clr   = 1'b0;
    LED   = 4'b0000;
    Sel   = 2'd0;
    model_reset();
    test_reset();
    test_single_channel();
    test_err_window();
    test_stall();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
